// File: rtl/zx81_sync_sep.sv
// zx81_sync_sep
//   Composite-sync separator for the ZX81 core. Measures the width of each
//   csync pulse, classifies it as a line sync (H), a frame sync (V), a glitch
//   or an error. From those events it rebuilds clean hsync/vsync, beam
//   counters, a frame-lock flag and a data-enable window, all in clk_sys.
//
//   Optional build macro: ZX81_SYNC_SEP_FILTER_EN
//     defined   : csync goes through a 3-sample majority filter, which removes
//                 isolated 1-cycle spikes (edge-to-event latency 3 cycles).
//     undefined : a single register stage (edge-to-event latency 2 cycles).
//
// Ports
//   clk_sys   in   system clock
//   reset_n   in   asynchronous active-low reset
//   csync     in   composite sync, high = sync asserted, synchronous to clk_sys
//   hsync     out  regenerated line sync, HS_OUT_W cycles per H event
//   vsync     out  regenerated frame sync, V event until the next H event
//   vde       out  video data enable
//   xpos      out  cycles since the last sync event, saturates at 2047
//   ypos      out  lines since the last frame sync, saturates at 511
//   locked    out  frame timing stable
//   sync_err  out  one-cycle pulse on an unclassifiable pulse width
//
// Lock FSM states
//   state    | meaning
//   UNLOCKED | no usable frame reference yet
//   ARMED    | one frame sync seen, measuring the next frame length
//   LOCKED   | last frame length in range and line syncs still arriving

module zx81_sync_sep #(
  parameter int HS_MIN_W    = 16,
  parameter int HS_MAX_W    = 128,
  parameter int VS_MIN_W    = 1024,
  parameter int HS_OUT_W    = 64,
  parameter int H_DE_START  = 128,
  parameter int H_DE_LEN    = 512,
  parameter int V_DE_START  = 56,
  parameter int V_DE_LEN    = 192,
  parameter int V_MIN_LINES = 240,
  parameter int V_MAX_LINES = 330
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        csync,
  output logic        hsync,
  output logic        vsync,
  output logic        vde,
  output logic [10:0] xpos,
  output logic [8:0]  ypos,
  output logic        locked,
  output logic        sync_err
);

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ARMED    = 2'd1,
    LOCKED   = 2'd2
  } lock_state_t;

  localparam logic [11:0] HS_MIN_C    = 12'(HS_MIN_W);
  localparam logic [11:0] HS_MAX_C    = 12'(HS_MAX_W);
  localparam logic [11:0] VS_MIN_C    = 12'(VS_MIN_W);
  localparam logic [11:0] HS_OUT_C    = 12'(HS_OUT_W);
  localparam logic [11:0] H_DE_LO_C   = 12'(H_DE_START);
  localparam logic [11:0] H_DE_HI_C   = 12'(H_DE_START + H_DE_LEN);
  localparam logic [11:0] V_DE_LO_C   = 12'(V_DE_START);
  localparam logic [11:0] V_DE_HI_C   = 12'(V_DE_START + V_DE_LEN);
  localparam logic [11:0] V_MIN_C     = 12'(V_MIN_LINES);
  localparam logic [11:0] V_MAX_C     = 12'(V_MAX_LINES);

  logic        cs_d, cs_q, cs_prev_q;
  logic [11:0] pw_d, pw_q;
  logic [10:0] xpos_d, xpos_q;
  logic [8:0]  ypos_d, ypos_q;
  logic [11:0] hs_cnt_d, hs_cnt_q;
  logic        vs_d, vs_q;
  logic        err_d, err_q;
  lock_state_t state_d, state_q;

  logic cs_rise, cs_fall;
  logic ev_h, ev_v, ev_err;
  logic x_sat, frame_in_range;

  // ---------------------------------------------------------------- input
`ifdef ZX81_SYNC_SEP_FILTER_EN
  logic [1:0] raw_d, raw_q;

  // Majority of the current sample and the two before it; a lone 1-cycle
  // spike never gets two votes.
  always_comb begin
    raw_d = {raw_q[0], csync};
    cs_d  = (csync & raw_q[0]) | (csync & raw_q[1]) | (raw_q[0] & raw_q[1]);
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) raw_q <= 2'b00;
    else          raw_q <= raw_d;
  end
`else
  assign cs_d = csync;
`endif

  assign cs_rise = cs_q & ~cs_prev_q;
  assign cs_fall = ~cs_q & cs_prev_q;

  // ------------------------------------------------------- classification
  // pw holds the pulse width in cycles by the time the falling edge is seen.
  always_comb begin
    pw_d = pw_q;
    if (cs_rise)                      pw_d = 12'd1;
    else if (cs_q && pw_q != 12'hFFF) pw_d = pw_q + 12'd1;
  end

  assign ev_h   = cs_fall && (pw_q >= HS_MIN_C) && (pw_q <= HS_MAX_C);
  assign ev_v   = cs_fall && (pw_q >= VS_MIN_C);
  assign ev_err = cs_fall && (pw_q >  HS_MAX_C) && (pw_q <  VS_MIN_C);

  // -------------------------------------------------------- beam counters
  assign x_sat          = (xpos_q == 11'h7FF);
  assign frame_in_range = ({3'b000, ypos_q} >= V_MIN_C) &&
                          ({3'b000, ypos_q} <= V_MAX_C);

  always_comb begin
    xpos_d = x_sat ? xpos_q : xpos_q + 11'd1;
    if (ev_h || ev_v) xpos_d = 11'd0;

    ypos_d = ypos_q;
    if (ev_h && ypos_q != 9'h1FF) ypos_d = ypos_q + 9'd1;
    if (ev_v)                     ypos_d = 9'd0;

    // hsync is high while the down-counter is non-zero.
    hs_cnt_d = hs_cnt_q;
    if (hs_cnt_q != 12'd0) hs_cnt_d = hs_cnt_q - 12'd1;
    if (ev_h)              hs_cnt_d = HS_OUT_C;
    if (ev_v)              hs_cnt_d = 12'd0;

    vs_d = vs_q;
    if (ev_v) vs_d = 1'b1;
    if (ev_h) vs_d = 1'b0;

    err_d = ev_err;
  end

  // ------------------------------------------------------------- lock FSM
  // The frame length is ypos_q as it stands when the V event is seen.
  always_comb begin
    state_d = state_q;
    case (state_q)
      UNLOCKED: if (ev_v) state_d = ARMED;
      ARMED:    if (ev_v) state_d = frame_in_range ? LOCKED : UNLOCKED;
      LOCKED:   if (x_sat || (ev_v && !frame_in_range)) state_d = UNLOCKED;
      default:  state_d = UNLOCKED;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      cs_q      <= 1'b0;
      cs_prev_q <= 1'b0;
      pw_q      <= 12'd0;
      xpos_q    <= 11'd0;
      ypos_q    <= 9'd0;
      hs_cnt_q  <= 12'd0;
      vs_q      <= 1'b0;
      err_q     <= 1'b0;
      state_q   <= UNLOCKED;
    end else begin
      cs_q      <= cs_d;
      cs_prev_q <= cs_q;
      pw_q      <= pw_d;
      xpos_q    <= xpos_d;
      ypos_q    <= ypos_d;
      hs_cnt_q  <= hs_cnt_d;
      vs_q      <= vs_d;
      err_q     <= err_d;
      state_q   <= state_d;
    end
  end

  // -------------------------------------------------------------- outputs
  assign hsync    = (hs_cnt_q != 12'd0);
  assign vsync    = vs_q;
  assign xpos     = xpos_q;
  assign ypos     = ypos_q;
  assign locked   = (state_q == LOCKED);
  assign sync_err = err_q;

  assign vde = locked && !vs_q &&
               ({1'b0, xpos_q}   >= H_DE_LO_C) && ({1'b0, xpos_q}   < H_DE_HI_C) &&
               ({3'b000, ypos_q} >= V_DE_LO_C) && ({3'b000, ypos_q} < V_DE_HI_C);

endmodule

// File: tb/tb_zx81_sync_sep.sv
module tb_zx81_sync_sep;

  localparam int HS_MIN = 16;
  localparam int HS_MAX = 128;
  localparam int VS_MIN = 1024;
  localparam int HS_OUT = 64;
  localparam int HDS    = 128;
  localparam int HDL    = 512;
  localparam int VDS    = 2;
  localparam int VDL    = 6;
  localparam int VMIN   = 8;
  localparam int VMAX   = 12;
`ifdef ZX81_SYNC_SEP_FILTER_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        csync = 1'b0;
  logic        hsync, vsync, vde, locked, sync_err;
  logic [10:0] xpos;
  logic [8:0]  ypos;

  always #5 clk_sys = ~clk_sys;

  zx81_sync_sep #(
    .HS_MIN_W(HS_MIN), .HS_MAX_W(HS_MAX), .VS_MIN_W(VS_MIN), .HS_OUT_W(HS_OUT),
    .H_DE_START(HDS), .H_DE_LEN(HDL), .V_DE_START(VDS), .V_DE_LEN(VDL),
    .V_MIN_LINES(VMIN), .V_MAX_LINES(VMAX)
  ) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .csync(csync),
    .hsync(hsync), .vsync(vsync), .vde(vde), .xpos(xpos), .ypos(ypos),
    .locked(locked), .sync_err(sync_err)
  );

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
  endtask

  // ------------------------------------------------------------------ model
  // Timestamp model: outputs follow from when the last H and V events were
  // registered (edge index k), not from a copy of the design's registers.
  int k, t_h, t_v, t_any, lines, lst, run;
  bit fa, fb, m_err;
`ifdef ZX81_SYNC_SEP_FILTER_EN
  bit r1, r2;
`endif

  task automatic m_reset();
    k = 0; t_h = -100000; t_v = -100000; t_any = 0; lines = 0; lst = 0;
    run = 0; fa = 0; fb = 0; m_err = 0;
`ifdef ZX81_SYNC_SEP_FILTER_EN
    r1 = 0; r2 = 0;
`endif
  endtask

  task automatic m_step();
    int  xprev, ev;
    bit  s, fn, in_rng;
    xprev = k - t_any;
    if (xprev > 2047) xprev = 2047;
    k++;
    ev = 0; m_err = 0;
    if (fb && !fa) begin
      if (run >= HS_MIN && run <= HS_MAX) ev = 1;
      else if (run >= VS_MIN)             ev = 2;
      else if (run > HS_MAX)              m_err = 1;
    end
    in_rng = (lines >= VMIN) && (lines <= VMAX);
    case (lst)
      0: if (ev == 2) lst = 1;
      1: if (ev == 2) lst = in_rng ? 2 : 0;
      default: if (xprev == 2047 || (ev == 2 && !in_rng)) lst = 0;
    endcase
    if (ev == 1) begin t_h = k; t_any = k; if (lines < 511) lines++; end
    if (ev == 2) begin t_v = k; t_any = k; lines = 0; end
    s = csync;
`ifdef ZX81_SYNC_SEP_FILTER_EN
    fn = (s && r1) || (s && r2) || (r1 && r2);
    r2 = r1; r1 = s;
`else
    fn = s;
`endif
    fb = fa; fa = fn;
    if (fn) run = fb ? ((run < 4095) ? run + 1 : 4095) : 1;
  endtask

  function automatic logic [31:0] m_exp();
    int x;
    bit hs, vs, de, lk;
    x  = k - t_any;
    if (x > 2047) x = 2047;
    hs = (t_h > t_v) && (k - t_h < HS_OUT);
    vs = (t_v > t_h);
    lk = (lst == 2);
    de = lk && !vs && x >= HDS && x < HDS + HDL && lines >= VDS && lines < VDS + VDL;
    return {7'd0, hs, vs, de, lk, m_err, 11'(x), 9'(lines)};
  endfunction

  always @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) m_reset();
    else          m_step();
  end

  always @(negedge clk_sys) begin
    if (reset_n && chk_en)
      check("cycle", {7'd0, hsync, vsync, vde, locked, sync_err, xpos, ypos}, m_exp());
  end

  int vde_cnt = 0;
  int err_cnt = 0;
  always @(negedge clk_sys) begin
    if (vde)      vde_cnt++;
    if (sync_err) err_cnt++;
  end

  // -------------------------------------------------------------- stimulus
  // Called at a negedge: csync high for w sampled cycles, then low for gap.
  task automatic send(input int w, input int gap, output bit h_before, output bit h_at,
                      output int x_before, output int x_at, output int hs_seen);
    h_before = 0; h_at = 0; x_before = -1; x_at = -1; hs_seen = 0;
    csync = 1'b1;
    repeat (w) @(negedge clk_sys);
    csync = 1'b0;
    for (int i = 1; i <= gap; i++) begin
      @(negedge clk_sys);
      if (i == LAT - 1) begin h_before = hsync; x_before = int'(xpos); end
      if (i == LAT)     begin h_at = hsync;     x_at = int'(xpos);     end
      if (hsync) hs_seen++;
    end
  endtask

  task automatic pulse(input int w, input int gap);
    bit a, b; int c, d, e;
    send(w, gap, a, b, c, d, e);
  endtask

  initial begin
    bit hb, ha;
    int xb, xa, hc, base, e0, x0, y0;

    repeat (3) @(negedge clk_sys);
    check("reset_outputs", {7'd0, hsync, vsync, vde, locked, sync_err, xpos, ypos}, 32'd0);
    reset_n = 1'b1;
    chk_en  = 1'b1;

    // line pulse train: 60 high / 772 low
    for (int ln = 0; ln < 4; ln++) begin
      send(60, 772, hb, ha, xb, xa, hc);
      check("hs_before_latency", 32'(hb), 32'd0);
      check("hs_at_latency", 32'(ha), 32'd1);
      check("x_cleared", 32'(xa), 32'd0);
      check("hs_width", 32'(hc), 32'd64);
      if (ln > 0) check("x_wrap_from", 32'(xb), 32'd831);
      check("ypos_line", 32'(ypos), 32'(ln + 1));
    end

    // first frame sync -> ARMED
    pulse(4000, 300);
    check("v1_vsync", 32'(vsync), 32'd1);
    check("v1_ypos", 32'(ypos), 32'd0);
    check("v1_locked", 32'(locked), 32'd0);
    pulse(60, 772);
    check("v1_vsync_drop", 32'(vsync), 32'd0);
    check("v1_first_line", 32'(ypos), 32'd1);
    for (int ln = 1; ln < 10; ln++) pulse(60, 772);
    pulse(1200, 300);
    check("v2_locked", 32'(locked), 32'd1);
    check("v2_ypos", 32'(ypos), 32'd0);
    check("v2_vsync", 32'(vsync), 32'd1);

    // data-enable frame
    base = vde_cnt;
    for (int ln = 0; ln < 10; ln++) pulse(60, 772);
    pulse(1200, 300);
    check("vde_per_frame", 32'(vde_cnt - base), 32'(VDL * HDL));
    check("v3_locked", 32'(locked), 32'd1);

    // classification errors
    pulse(60, 100);
    x0 = int'(xpos); y0 = int'(ypos); e0 = err_cnt;
    pulse(8, 100);
    check("glitch_x", 32'(xpos), 32'(x0 + 108));
    check("glitch_y", 32'(ypos), 32'(y0));
    check("glitch_noerr", 32'(err_cnt - e0), 32'd0);
    pulse(500, 100);
    check("err_x", 32'(xpos), 32'(x0 + 708));
    check("err_y", 32'(ypos), 32'(y0));
    check("err_once", 32'(err_cnt - e0), 32'd1);
    pulse(1, 50);
    check("spike_x", 32'(xpos), 32'(x0 + 759));
    check("spike_noerr", 32'(err_cnt - e0), 32'd1);
    check("still_locked", 32'(locked), 32'd1);

    // sync loss
    csync = 1'b0;
    repeat (2100) @(negedge clk_sys);
    check("loss_xsat", 32'(xpos), 32'd2047);
    check("loss_unlock", 32'(locked), 32'd0);

    // relock, then a short frame
    pulse(1200, 300);
    check("relock_armed", 32'(locked), 32'd0);
    for (int ln = 0; ln < 10; ln++) pulse(60, 772);
    pulse(1200, 300);
    check("relock_locked", 32'(locked), 32'd1);
    for (int ln = 0; ln < 3; ln++) pulse(60, 772);
    pulse(1200, 300);
    check("short_frame_unlock", 32'(locked), 32'd0);

    // width boundaries
    e0 = err_cnt;
    begin
      int widths [6] = '{15, 16, 128, 129, 1023, 1024};
      foreach (widths[i]) pulse(widths[i], 100);
    end
    check("boundary_errs", 32'(err_cnt - e0), 32'd2);

    // reset mid-pulse
    pulse(60, 300);
    csync = 1'b1;
    repeat (20) @(negedge clk_sys);
    reset_n = 1'b0;
    #1;
    check("async_reset", {7'd0, hsync, vsync, vde, locked, sync_err, xpos, ypos}, 32'd0);
    @(negedge clk_sys);
    reset_n = 1'b1;
    repeat (10) @(negedge clk_sys);
    csync = 1'b0;
    repeat (100) @(negedge clk_sys);

    // randomized pulse stream
    for (int i = 0; i < 30; i++) begin
      int cat, w, g;
      cat = $urandom_range(0, 7);
      if (cat == 0)      w = $urandom_range(1, 15);
      else if (cat <= 5) w = $urandom_range(16, 128);
      else if (cat == 6) w = $urandom_range(129, 300);
      else               w = $urandom_range(1024, 1100);
      g = (($urandom_range(0, 5)) == 0) ? $urandom_range(1, 4) : $urandom_range(20, 700);
      pulse(w, g);
    end
    repeat (20) @(negedge clk_sys);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
